// File: rtl/accum_64bit_pkg.sv
// Shared definitions for the 64-bit streaming accumulator.
package accum_64bit_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/RCA_64bit.sv
// 64-bit ripple-carry adder: sum = a + b + c_in, carry out of bit 63 on c_out.
module RCA_64bit (
  output logic        c_out,
  output logic [63:0] sum,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in
);

  // Bit-serial carry chain; the carry is a block-local variable so the chain stays one comb process.
  always_comb begin
    logic v_c;
    v_c = c_in;
    sum = '0;
    for (int i = 0; i < 64; i++) begin
      sum[i] = a[i] ^ b[i] ^ v_c;
      v_c    = (a[i] & b[i]) | (v_c & (a[i] ^ b[i]));
    end
    c_out = v_c;
  end

endmodule

// File: rtl/accum_64bit.sv
// Streaming multi-operand accumulator around RCA_64bit with sticky carry/overflow flags.
module accum_64bit
  import accum_64bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_acc_next;
  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   w_rem_next;
  logic               r_carry;
  logic               w_carry_next;
  logic               r_ovf;
  logic               w_ovf_next;
  logic [WIDTH-1:0]   w_sum;
  logic               w_c_out;
  logic               w_ovf_add;

  RCA_64bit u_rca (
    .c_out (w_c_out),
    .sum   (w_sum),
    .a     (r_acc),
    .b     (in_data),
    .c_in  (1'b0)
  );

  // Signed overflow: operands share a sign and the result sign differs.
  assign w_ovf_add = (r_acc[WIDTH-1] == in_data[WIDTH-1]) & (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

  // State, accumulator, counter and sticky flags; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_rem   <= w_rem_next;
      r_carry <= w_carry_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Next-state and handshake decode; ready/valid depend only on registered state.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_rem_next   = r_rem;
    w_carry_next = r_carry;
    w_ovf_next   = r_ovf;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_acc_next   = '0;
          w_carry_next = 1'b0;
          w_ovf_next   = 1'b0;
          if (num_ops != '0) begin
            w_rem_next   = num_ops;
            w_state_next = ST_ACCUM;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_acc_next   = w_sum;
          w_carry_next = r_carry | w_c_out;
          w_ovf_next   = r_ovf | w_ovf_add;
          w_rem_next   = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign out_sum   = r_acc;
  assign out_carry = r_carry;
  assign out_ovf   = r_ovf;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_accum_64bit.sv
// Directed self-checking bench for accum_64bit.
module tb_accum_64bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  num_ops;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        busy;

  int n_cmp;
  int n_err;

  accum_64bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input logic [7:0] n);
    start   = 1'b1;
    num_ops = n;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_busy",      busy,      0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready",  in_ready,  0);
    check_eq("rst_sum",       out_sum,   0);
    check_eq("rst_carry",     out_carry, 0);
    check_eq("rst_ovf",       out_ovf,   0);

    // Reset mid-burst
    begin_burst(8'd3);
    check_eq("mid_in_ready", in_ready, 1);
    check_eq("mid_busy",     busy,     1);
    feed(64'd5);
    check_eq("mid_acc", out_sum, 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_busy",  busy,      0);
    check_eq("mid_rst_sum",   out_sum,   0);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ready", in_ready,  0);
    check_eq("mid_rst_carry", out_carry, 0);
    check_eq("mid_rst_ovf",   out_ovf,   0);

    // Basic sum, back-to-back operands
    begin_burst(8'd3);
    feed(64'd5);
    feed(64'd10);
    check_eq("basic_valid_early", out_valid, 0);
    feed(64'h100);
    check_eq("basic_valid", out_valid, 1);
    check_eq("basic_sum",   out_sum,   64'h10F);
    check_eq("basic_carry", out_carry, 0);
    check_eq("basic_ovf",   out_ovf,   0);
    check_eq("basic_in_rdy", in_ready, 0);
    take_result();
    check_eq("basic_idle",   busy,      0);
    check_eq("basic_ovalid", out_valid, 0);
    check_eq("basic_retain", out_sum,   64'h10F);

    // Unsigned wrap
    begin_burst(8'd2);
    feed(64'hFFFF_FFFF_FFFF_FFFF);
    feed(64'd2);
    check_eq("wrap_valid", out_valid, 1);
    check_eq("wrap_sum",   out_sum,   64'd1);
    check_eq("wrap_carry", out_carry, 1);
    check_eq("wrap_ovf",   out_ovf,   0);
    take_result();

    // Signed overflow; flags from previous burst must be cleared by start
    begin_burst(8'd2);
    feed(64'h7FFF_FFFF_FFFF_FFFF);
    feed(64'd1);
    check_eq("sovf_sum",   out_sum,   64'h8000_0000_0000_0000);
    check_eq("sovf_ovf",   out_ovf,   1);
    check_eq("sovf_carry", out_carry, 0);
    take_result();

    // Bubbles and backpressure
    begin_burst(8'd4);
    feed(64'd1);
    bubble();
    check_eq("bub_sum_hold", out_sum, 64'd1);
    feed(64'd2);
    bubble();
    check_eq("bub_busy",  busy,      1);
    check_eq("bub_valid", out_valid, 0);
    feed(64'd3);
    check_eq("bub_valid_early", out_valid, 0);
    feed(64'd4);
    check_eq("bub_sum",   out_sum,   64'd10);
    check_eq("bub_flags", {out_carry, out_ovf}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_valid_%0d", i), out_valid, 1);
      check_eq($sformatf("stall_sum_%0d", i),   out_sum,   64'd10);
    end
    take_result();
    check_eq("bub_idle", busy, 0);

    // Zero-count burst goes straight to DONE with a zero result
    begin_burst(8'd0);
    check_eq("zero_valid", out_valid, 1);
    check_eq("zero_sum",   out_sum,   0);
    check_eq("zero_busy",  busy,      1);
    take_result();

    // Start while in ACCUM is ignored; remaining count stays at one
    begin_burst(8'd2);
    feed(64'd7);
    start   = 1'b1;
    num_ops = 8'd7;
    tick();
    start   = 1'b0;
    check_eq("ign_busy",  busy,      1);
    check_eq("ign_valid", out_valid, 0);
    check_eq("ign_sum",   out_sum,   64'd7);
    feed(64'd8);
    check_eq("ign_done", out_valid, 1);
    check_eq("ign_sum2", out_sum,   64'd15);
    // Start while in DONE is ignored too
    start   = 1'b1;
    num_ops = 8'd0;
    tick();
    start   = 1'b0;
    check_eq("done_start_valid", out_valid, 1);
    check_eq("done_start_sum",   out_sum,   64'd15);
    take_result();
    check_eq("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accum_64bit.md
Name: accum_64bit

Overview:
Streaming multi-operand accumulator that sits around the team's 64-bit ripple-carry adder. It both feeds the adder, with the running sum and the next operand, and consumes its sum and carry-out. A burst of num_ops 64-bit operands arrives over a valid/ready input. After the last operand it presents the total on a valid/ready output, together with sticky unsigned-carry and signed-overflow flags.

Parameters:
WIDTH, 64, operand/sum width; fixed at 64 to match RCA_64bit.
CNT_W, 8, width of the operand-count field; a burst holds at most 2^CNT_W-1 operands.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a burst; sampled only in IDLE
num_ops  input  CNT_W  operand count for the burst; sampled with start
in_valid  input  1  in_data is valid
in_ready  output  1  accumulator accepts an operand this cycle
in_data  input  WIDTH  operand
out_valid  output  1  result is available
out_ready  input  1  consumer takes the result
out_sum  output  WIDTH  accumulated sum, modulo 2^64
out_carry  output  1  sticky: any add produced c_out=1 (unsigned wrap)
out_ovf  output  1  sticky: any add caused two's-complement overflow
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: one clock and one reset. rst is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: state=IDLE, acc=0, remaining=0, out_carry=0, out_ovf=0, in_ready=0, out_valid=0, busy=0. out_sum mirrors acc, so it also resets to 0.
- rst asserted in any state aborts the burst and returns to these values on the next edge. Any partial result is discarded.
- States: IDLE, ACCUM, DONE; encoding is 2 bits.
- IDLE:
  - start=1 and num_ops!=0: acc<=0, flags<=0, remaining<=num_ops, go to ACCUM.
  - start=1 and num_ops==0: acc<=0, flags<=0, go directly to DONE (result is 0).
  - start=0: stay in IDLE.
- ACCUM:
  - in_ready=1, registered-state decode with no combinational dependence on in_valid.
  - On in_valid & in_ready: acc<=RCA_64bit(acc, in_data, c_in=0).sum.
  - out_carry |= c_out.
  - out_ovf |= (acc[63]==in_data[63]) & (sum[63]!=acc[63]).
  - remaining<=remaining-1.
  - When an operand is accepted with remaining==1, go to DONE.
  - Throughput is one operand per cycle. in_valid gaps stall with no change to state.
- DONE:
  - out_valid=1; out_sum, out_carry and out_ovf are held stable until handshake.
  - On out_valid & out_ready: go to IDLE; acc and flags are retained until the next start.
- Latency: out_valid rises on the cycle after the final operand is accepted.
- start outside IDLE is ignored. A new burst cannot overlap DONE; the earliest restart is the cycle after the output handshake.
- Arithmetic is modulo 2^64. Wrap-around is not saturated; it is reported only through the sticky flags.
- The critical path is the combinational 64-bit ripple through the adder in a single cycle. There is no internal pipelining.

Decomposition:
- Shared package: state localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2, plus WIDTH and CNT_W defaults.
- Sub-module: one instance of the existing RCA_64bit, ports (c_out, sum, a, b, c_in), with a=acc, b=in_data, c_in=0.
- The FSM, counter and flag logic stay in accum_64bit.

Test Plan:
- Reset mid-burst: start, num_ops=3, accept 1 operand, assert rst -> next cycle state IDLE, acc=0, busy=0, out_valid=0, flags=0.
- Basic sum: num_ops=3, operands 5, 10, 0x100 back-to-back -> out_valid the cycle after the 3rd; out_sum=0x10F; out_carry=0; out_ovf=0.
- Unsigned wrap: num_ops=2, operands 0xFFFF_FFFF_FFFF_FFFF and 2 -> out_sum=1, out_carry=1, out_ovf=0.
- Signed overflow: num_ops=2, operands 0x7FFF_FFFF_FFFF_FFFF and 1 -> out_sum=0x8000_0000_0000_0000, out_ovf=1, out_carry=0.
- Bubbles and backpressure: num_ops=4, in_valid toggled 1,0,1,0,1,1 with operands 1,2,3,4; hold out_ready=0 for 3 cycles -> out_sum=10; out_valid and out_sum stable while stalled; IDLE one cycle after out_ready=1.
- Zero count and ignored start: num_ops=0 -> DONE next cycle with out_sum=0. While in ACCUM, pulse start with num_ops=7 -> ignored; the remaining count is unchanged.
